// File: rtl/wm_panel_if.sv
// Front-panel signal bundle between the raw panel/wash FSM side and wm_panel_ctrl.
// master drives the raw buttons, sensors and program_done; slave is the panel controller.
interface wm_panel_if;
  logic       btn_power;
  logic       btn_start;
  logic       btn_prog_next;
  logic       door_sensor;
  logic       soap_sensor;
  logic       program_done;
  logic       power;
  logic       start;
  logic [2:0] program_selection;
  logic       doorclosed;
  logic       soap;
  logic       door_lock;
  logic       busy;
  logic       start_reject;

  modport master (
    output btn_power, btn_start, btn_prog_next, door_sensor, soap_sensor, program_done,
    input  power, start, program_selection, doorclosed, soap, door_lock, busy, start_reject
  );

  modport slave (
    input  btn_power, btn_start, btn_prog_next, door_sensor, soap_sensor, program_done,
    output power, start, program_selection, doorclosed, soap, door_lock, busy, start_reject
  );
endinterface

// File: rtl/wm_panel_ctrl.sv
// Washing-machine front panel: sync + debounce of raw inputs, power/program state, start strobe, door lock.
// Optional idle auto power-off in READY is enabled by defining PANEL_AUTO_OFF_EN.
//
// state        | meaning
// ST_OFF       | panel unpowered, only a power press is honoured
// ST_READY     | powered, idle; power/start/prog_next presses handled in that priority
// ST_RUNNING   | wash program active, door locked, all presses ignored
// ST_DONE_HOLD | program finished, door held locked for UNLOCK_DELAY cycles
module wm_panel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int UNLOCK_DELAY    = 3,
  parameter int AUTO_OFF_CYCLES = 200
) (
  input logic        clk,
  input logic        rst,
  wm_panel_if.slave  pnl
);

  localparam int NIN    = 5;
  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(UNLOCK_DELAY + 1);

  typedef enum logic [1:0] {ST_OFF, ST_READY, ST_RUNNING, ST_DONE_HOLD} state_e;

  // bit order: 0 power, 1 start, 2 prog_next, 3 door, 4 soap
  logic [NIN-1:0]   raw;
  logic [NIN-1:0]   sync1_q, sync2_q;
  logic [NIN-1:0]   lvl_q, lvl_d;
  logic [CNT_W-1:0] cnt_q [NIN];
  logic [CNT_W-1:0] cnt_d [NIN];

  state_e           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic             start_q, start_d;
  logic             rej_q, rej_d;
  logic             press_power, press_start, press_next;

`ifdef PANEL_AUTO_OFF_EN
  localparam int IDLE_W = $clog2(AUTO_OFF_CYCLES);
  logic [IDLE_W-1:0] idle_q, idle_d;
`endif

  assign raw = {pnl.soap_sensor, pnl.door_sensor, pnl.btn_prog_next, pnl.btn_start, pnl.btn_power};

  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < NIN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) lvl_d[i] = sync2_q[i];
        else                                       cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Presses are taken from the debounced level as it changes, so the FSM reacts on the same edge.
  assign press_power = lvl_d[0] & ~lvl_q[0];
  assign press_start = lvl_d[1] & ~lvl_q[1];
  assign press_next  = lvl_d[2] & ~lvl_q[2];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    start_d = 1'b0;
    rej_d   = 1'b0;
`ifdef PANEL_AUTO_OFF_EN
    idle_d  = idle_q;
`endif
    case (state_q)
      ST_OFF: begin
        if (press_power) begin
          state_d = ST_READY;
`ifdef PANEL_AUTO_OFF_EN
          idle_d  = '0;
`endif
        end
      end
      ST_READY: begin
        if (press_power) begin
          state_d = ST_OFF;
        end else if (press_start) begin
          if (lvl_q[3]) begin
            start_d = 1'b1;
            state_d = ST_RUNNING;
          end else begin
            rej_d = 1'b1;
          end
        end else if (press_next) begin
          sel_d = (sel_q == 3'd4) ? 3'd0 : sel_q + 3'd1;
        end
`ifdef PANEL_AUTO_OFF_EN
        if (press_power || press_start || press_next) idle_d = '0;
        else if (idle_q == IDLE_W'(AUTO_OFF_CYCLES - 1)) state_d = ST_OFF;
        else idle_d = idle_q + IDLE_W'(1);
`endif
      end
      ST_RUNNING: begin
        if (pnl.program_done) begin
          state_d = ST_DONE_HOLD;
          hold_d  = HOLD_W'(UNLOCK_DELAY);
        end
      end
      ST_DONE_HOLD: begin
        hold_d = hold_q - HOLD_W'(1);
        if (hold_q <= HOLD_W'(1)) begin
          state_d = ST_READY;
`ifdef PANEL_AUTO_OFF_EN
          idle_d  = '0;
`endif
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      for (int i = 0; i < NIN; i++) cnt_q[i] <= '0;
      state_q <= ST_OFF;
      sel_q   <= '0;
      hold_q  <= '0;
      start_q <= 1'b0;
      rej_q   <= 1'b0;
`ifdef PANEL_AUTO_OFF_EN
      idle_q  <= '0;
`endif
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      for (int i = 0; i < NIN; i++) cnt_q[i] <= cnt_d[i];
      state_q <= state_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      start_q <= start_d;
      rej_q   <= rej_d;
`ifdef PANEL_AUTO_OFF_EN
      idle_q  <= idle_d;
`endif
    end
  end

  assign pnl.power             = (state_q != ST_OFF);
  assign pnl.start             = start_q;
  assign pnl.start_reject      = rej_q;
  assign pnl.program_selection = sel_q;
  assign pnl.doorclosed        = lvl_q[3];
  assign pnl.soap              = lvl_q[4];
  assign pnl.door_lock         = (state_q == ST_RUNNING) || (state_q == ST_DONE_HOLD);
  assign pnl.busy              = (state_q == ST_RUNNING) || (state_q == ST_DONE_HOLD);

endmodule

// File: tb/tb_wm_panel_ctrl.sv
// Self-checking bench for wm_panel_ctrl: directed scenarios plus random stimulus against a
// window-based debounce and mode-level panel model.
module tb_wm_panel_ctrl;
  localparam int D    = 4;
  localparam int U    = 3;
  localparam int AOFF = 200;
  localparam int M_OFF = 0, M_READY = 1, M_RUN = 2, M_HOLD = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  wm_panel_if pif ();

  wm_panel_ctrl #(.DEBOUNCE_CYCLES(D), .UNLOCK_DELAY(U), .AUTO_OFF_CYCLES(AOFF)) dut (
    .clk (clk),
    .rst (rst),
    .pnl (pif.slave)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // raw input bit order: 0 power, 1 start, 2 prog_next, 3 door, 4 soap
  logic [4:0] cur = '0;
  logic [4:0] m_hist [D+2];
  logic [4:0] m_lvl;
  int m_mode, m_sel, m_hold, m_idle;
  bit m_start, m_rej;

  function automatic void model_edge(logic [4:0] raw, logic pd, logic r);
    logic [4:0] nl, pr;
    bit flip;
    if (!r) begin
      for (int k = 0; k < D + 2; k++) m_hist[k] = '0;
      m_lvl = '0; m_mode = M_OFF; m_sel = 0; m_hold = 0; m_idle = 0;
      m_start = 0; m_rej = 0;
      return;
    end
    for (int k = D + 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = raw;
    // a level flips once the raw input, seen two samples late, has disagreed with it D times running
    nl = m_lvl;
    for (int i = 0; i < 5; i++) begin
      flip = 1;
      for (int k = 2; k <= D + 1; k++) if (m_hist[k][i] == m_lvl[i]) flip = 0;
      if (flip) nl[i] = ~m_lvl[i];
    end
    pr = nl & ~m_lvl;
    m_start = 0; m_rej = 0;
    case (m_mode)
      M_OFF: if (pr[0]) begin m_mode = M_READY; m_idle = 0; end
      M_READY: begin
        if (pr[0]) m_mode = M_OFF;
        else if (pr[1]) begin
          if (m_lvl[3]) begin m_start = 1; m_mode = M_RUN; end
          else m_rej = 1;
        end else if (pr[2]) m_sel = (m_sel + 1) % 5;
`ifdef PANEL_AUTO_OFF_EN
        if (pr[2:0] != 0) m_idle = 0;
        else begin
          m_idle++;
          if (m_idle == AOFF) m_mode = M_OFF;
        end
`endif
      end
      M_RUN: if (pd) begin m_mode = M_HOLD; m_hold = U; end
      default: begin
        m_hold--;
        if (m_hold == 0) begin m_mode = M_READY; m_idle = 0; end
      end
    endcase
    m_lvl = nl;
  endfunction

  function automatic logic [9:0] exp_vec();
    logic lk;
    lk = (m_mode == M_RUN) || (m_mode == M_HOLD);
    return {m_mode != M_OFF, m_start, 3'(m_sel), m_lvl[3], m_lvl[4], lk, lk, m_rej};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {pif.power, pif.start, pif.program_selection, pif.doorclosed, pif.soap,
            pif.door_lock, pif.busy, pif.start_reject};
  endfunction

  task automatic step(input logic [4:0] raw, input logic pd, input logic r);
    @(negedge clk);
    {pif.soap_sensor, pif.door_sensor, pif.btn_prog_next, pif.btn_start, pif.btn_power} = raw;
    pif.program_done = pd;
    rst = r;
    @(posedge clk);
    model_edge(raw, pd, r);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      step(5'($urandom), 1'($urandom), 1'b0);
      vectors++;
      if (dut_vec() !== 10'b0) begin
        miscompares++;
        $display("FAIL reset_outputs got=%b exp=%b", dut_vec(), 10'b0);
      end
    end
    cur = '0;
    for (int c = 0; c < D + 3; c++) begin
      step(cur, 1'b0, 1'b1);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_release got=%b exp=%b", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_power_on();
    for (int c = 1; c <= 18; c++) begin
      cur[0] = (c <= 10);
      step(cur, 1'b0, 1'b1);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL power_on_model c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
      end
      if (c == 5 || c == 6) begin
        vectors++;
        if (pif.power !== (c == 6) || pif.program_selection !== 3'd0) begin
          miscompares++;
          $display("FAIL power_on_latency c=%0d power=%b sel=%b exp power=%0d sel=000",
                   c, pif.power, pif.program_selection, c == 6);
        end
      end
    end
  endtask

  task automatic test_prog_next();
    int exp_sel [6] = '{1, 2, 3, 4, 0, 1};
    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < 12; c++) begin
        cur[2] = (c < 6);
        step(cur, 1'b0, 1'b1);
        vectors++;
        if (dut_vec() !== exp_vec()) begin
          miscompares++;
          $display("FAIL prog_next_model got=%b exp=%b", dut_vec(), exp_vec());
        end
      end
      vectors++;
      if (pif.program_selection !== 3'(exp_sel[p])) begin
        miscompares++;
        $display("FAIL prog_next_sel press=%0d got=%b exp=%0d", p, pif.program_selection, exp_sel[p]);
      end
    end
    for (int c = 0; c < 10; c++) begin
      cur[2] = (c < 2);
      step(cur, 1'b0, 1'b1);
      vectors++;
      if (dut_vec() !== exp_vec() || pif.program_selection !== 3'd1) begin
        miscompares++;
        $display("FAIL prog_glitch got=%b exp=%b", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_start_reject();
    int rej_n = 0, start_n = 0;
    for (int c = 0; c < 12; c++) begin
      cur[1] = (c < 6);
      step(cur, 1'b0, 1'b1);
      rej_n += pif.start_reject; start_n += pif.start;
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reject_model got=%b exp=%b", dut_vec(), exp_vec());
      end
    end
    vectors++;
    if (rej_n != 1 || start_n != 0 || pif.power !== 1'b1 || pif.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reject_pulse rej=%0d start=%0d power=%b busy=%b exp rej=1 start=0 power=1 busy=0",
               rej_n, start_n, pif.power, pif.busy);
    end
    cur[3] = 1'b1;
    start_n = 0;
    for (int c = 0; c < 18; c++) begin
      cur[1] = (c >= 8 && c < 14);
      step(cur, 1'b0, 1'b1);
      start_n += pif.start;
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL start_model got=%b exp=%b", dut_vec(), exp_vec());
      end
    end
    vectors++;
    if (start_n != 1 || pif.door_lock !== 1'b1 || pif.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL start_strobe starts=%0d lock=%b busy=%b exp 1 1 1", start_n, pif.door_lock, pif.busy);
    end
  endtask

  task automatic test_running();
    int n = 0;
    for (int c = 0; c < 12; c++) begin
      cur[0] = (c < 6); cur[2] = (c < 6);
      step(cur, 1'b0, 1'b1);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL running_model got=%b exp=%b", dut_vec(), exp_vec());
      end
    end
    vectors++;
    if (pif.power !== 1'b1 || pif.busy !== 1'b1 || pif.program_selection !== 3'd1) begin
      miscompares++;
      $display("FAIL running_ignore power=%b busy=%b sel=%b exp 1 1 001", pif.power, pif.busy, pif.program_selection);
    end
    step(cur, 1'b1, 1'b1);
    while (pif.door_lock === 1'b1 && n < 10) begin
      step(cur, 1'b0, 1'b1);
      n++;
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL unlock_model got=%b exp=%b", dut_vec(), exp_vec());
      end
    end
    vectors++;
    if (n != U || pif.busy !== 1'b0 || pif.power !== 1'b1) begin
      miscompares++;
      $display("FAIL unlock_delay cycles=%0d busy=%b power=%b exp cycles=%0d busy=0 power=1", n, pif.busy, pif.power, U);
    end
  endtask

  task automatic test_simultaneous();
    int start_n = 0;
    for (int c = 0; c < 10; c++) begin
      cur[1] = (c < 6); cur[2] = (c < 6);
      step(cur, 1'b0, 1'b1);
      start_n += pif.start;
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL simul_model got=%b exp=%b", dut_vec(), exp_vec());
      end
    end
    vectors++;
    if (start_n != 1 || pif.program_selection !== 3'd1 || pif.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_priority starts=%0d sel=%b busy=%b exp 1 001 1", start_n, pif.program_selection, pif.busy);
    end
    step(cur, 1'b0, 1'b0);
    vectors++;
    if (dut_vec() !== 10'b0 || dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_mid_run got=%b exp=%b", dut_vec(), 10'b0);
    end
  endtask

  task automatic test_random();
    logic pd, r;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 3; i++) if ($urandom_range(9) == 0) cur[i] = ~cur[i];
      if ($urandom_range(39) == 0) cur[3] = ~cur[3];
      if ($urandom_range(19) == 0) cur[4] = ~cur[4];
      pd = ($urandom_range(15) == 0);
      r  = ($urandom_range(799) != 0);
      step(cur, pd, r);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    {pif.soap_sensor, pif.door_sensor, pif.btn_prog_next, pif.btn_start, pif.btn_power} = '0;
    pif.program_done = 1'b0;
    model_edge('0, 1'b0, 1'b0);
    test_reset();
    test_power_on();
    test_prog_next();
    test_start_reject();
    test_running();
    test_simultaneous();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wm_panel_ctrl.md
Name: wm_panel_ctrl

Overview:
Front-panel input stage for the washing-machine controller; sits directly upstream of the wash-sequence FSM. Synchronises and debounces the raw buttons and sensors, and holds the power state and the selected program. Issues a single-cycle start strobe, and drives the door lock from start until the FSM's program_done plus a release delay.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles required before a debounced level changes (>=2)
UNLOCK_DELAY, 3, cycles door_lock stays asserted after program_done (>=1)
AUTO_OFF_CYCLES, 200, idle cycles in READY before auto power-off (used only with PANEL_AUTO_OFF_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-low reset
btn_power  in  1  raw power button, active-high, asynchronous to clk
btn_start  in  1  raw start button
btn_prog_next  in  1  raw program-select button
door_sensor  in  1  raw door switch, 1 = closed
soap_sensor  in  1  raw soap-present sensor
program_done  in  1  from wash FSM, one-cycle completion pulse
power  out  1  panel powered
start  out  1  one-cycle start strobe to FSM
program_selection  out  3  program code 000..100 to FSM
doorclosed  out  1  debounced door level
soap  out  1  debounced soap level
door_lock  out  1  door lock solenoid
busy  out  1  program running (RUNNING or DONE_HOLD)
start_reject  out  1  one-cycle pulse: start pressed with door open

Behaviour:
- Reset (rst==0 at a clk edge): state OFF; all outputs 0; program_selection=000; sync flops, debounce levels and counters cleared to 0.
- Every raw input passes through a 2-flop synchroniser, then a debouncer.
  - Debouncer: if sync != level, cnt++; when cnt reaches DEBOUNCE_CYCLES-1 with sync still != level, level<=sync and cnt<=0. If sync==level, cnt<=0.
  - Raw step to debounced change = 2+DEBOUNCE_CYCLES edges (6 at default). Glitches shorter than DEBOUNCE_CYCLES synchronised cycles never propagate.
- Press = one-cycle rising edge of a debounced button level. A held button produces exactly one press.
- FSM states:
  - OFF: power=0. Power press -> READY.
  - READY: power=1. Priority order: power press -> OFF (selection retained). Start press with doorclosed=1 -> start=1 for 1 cycle, door_lock=1, -> RUNNING. Start press with doorclosed=0 -> start_reject=1 for 1 cycle, stay. prog_next press -> selection+1, 100 wraps to 000.
  - RUNNING: power=1, door_lock=1, busy=1. All button presses ignored, including power. program_done -> DONE_HOLD, counter loaded UNLOCK_DELAY.
  - DONE_HOLD: door_lock=1, busy=1. Counter decrements each cycle; at 0 -> READY, door_lock=0 from that cycle. Presses ignored.
- Simultaneous presses in READY: power beats start beats prog_next. The loser is discarded, not queued.
- Power and start pressed together in OFF: -> READY only, no start strobe.
- start is registered and asserted in the same cycle the state becomes RUNNING.
- doorclosed and soap are driven from the debounced levels in every state, including OFF.
- Reset mid-program returns to OFF immediately and releases door_lock.

Optional Feature:
PANEL_AUTO_OFF_EN
- Defined: an idle counter runs only in READY and is cleared by any press or by entering READY. When it reaches AUTO_OFF_CYCLES-1, state -> OFF.
- Undefined: no idle counter; READY persists indefinitely.

Test Plan:
- Reset, then btn_power held high 10 cycles -> power=1 exactly 6 edges after btn_power rises (2 sync + 4 debounce); selection=000.
- In READY, 6 prog_next presses -> selection 001,010,011,100,000,001. A 2-cycle glitch on btn_prog_next -> no change.
- door_sensor=0, start press -> start_reject one cycle, start=0, state READY. Close door, start press -> start=1 for one cycle, door_lock=1, busy=1.
- In RUNNING, press power and prog_next -> no change. Pulse program_done -> door_lock drops 3 cycles later; busy=0; state READY.
- Start and prog_next debounced edges in the same cycle -> start strobe, selection unchanged. Drive rst=0 during RUNNING -> next edge all outputs 0.
- With PANEL_AUTO_OFF_EN and AUTO_OFF_CYCLES=20: idle in READY -> power=0 after 20 cycles. A press at cycle 15 restarts the count.
